// File: rtl/sfp_pkg.sv
// Shared types and helpers for the sfp_accum slice.
//   sfp_state_e : controller state encoding (Idle/Accum/Drain).
//   ADDR_W()    : buffer address width for a given depth.
//   PASS_W()    : pass counter width for a given pass count (holds 0..pass_num).
package sfp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDrain = 2'd2
  } sfp_state_e;

  function automatic int unsigned ADDR_W(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned PASS_W(input int unsigned pass_num);
    return (pass_num < 1) ? 1 : $clog2(pass_num + 1);
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One lane of the accumulator datapath.
//   acc_i  : current buffer value at the write address
//   add_i  : incoming psum for this lane
//   load_i : first pass, the incoming psum replaces the stored value
//   sum_o  : value to write back into the buffer
//   rd_i   : buffer value at the read address
//   relu_o : max(rd_i, 0)
// Build option: define SFP_SATURATE_EN to clamp the addition to the signed range
// instead of wrapping modulo 2^psum_bw.
module sfp_lane #(
  parameter int unsigned psum_bw = 16
) (
  input  logic [psum_bw-1:0] acc_i,
  input  logic [psum_bw-1:0] add_i,
  input  logic               load_i,
  output logic [psum_bw-1:0] sum_o,
  input  logic [psum_bw-1:0] rd_i,
  output logic [psum_bw-1:0] relu_o
);

  logic [psum_bw-1:0] add_res;

`ifdef SFP_SATURATE_EN
  localparam logic [psum_bw-1:0] MaxVal = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MinVal = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw:0] wide;

  always_comb begin
    wide = {acc_i[psum_bw-1], acc_i} + {add_i[psum_bw-1], add_i};
    // Top two bits disagree only when the signed sum left the representable range.
    if (wide[psum_bw] != wide[psum_bw-1]) begin
      add_res = wide[psum_bw] ? MinVal : MaxVal;
    end else begin
      add_res = wide[psum_bw-1:0];
    end
  end
`else
  always_comb begin
    add_res = acc_i + add_i;
  end
`endif

  always_comb begin
    sum_o  = load_i ? add_i : add_res;
    relu_o = rd_i[psum_bw-1] ? '0 : rd_i;
  end

endmodule

// File: rtl/sfp_accum.sv
// On-chip psum accumulator behind the core's output FIFO.
// Accumulates pass_num passes of depth col-wide vectors, then drains ReLU'd results.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a tile (only honoured in Idle)
//   in_valid/in_ready   : input beat handshake, in_data lane i at [i*psum_bw +: psum_bw]
//   out_valid/out_ready : output handshake, out_data same packing, ReLU applied
//   done                : one-cycle pulse after the last output handshake
//   busy                : high while accumulating or draining
// Build option: SFP_SATURATE_EN selects saturating lane addition (see sfp_lane).
module sfp_accum
  import sfp_pkg::*;
#(
  parameter int unsigned psum_bw  = 16,
  parameter int unsigned col      = 8,
  parameter int unsigned depth    = 16,
  parameter int unsigned pass_num = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   done,
  output logic                   busy
);

  localparam int unsigned AddrW = ADDR_W(depth);
  localparam int unsigned PassW = PASS_W(pass_num);
  localparam int unsigned VecW  = col * psum_bw;

  localparam logic [AddrW-1:0] LastAddr = AddrW'(depth - 1);
  localparam logic [PassW-1:0] LastPass = PassW'(pass_num - 1);

  sfp_state_e       state_q, state_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
  logic             done_q, done_d;

  logic [VecW-1:0]  acc_q [depth];
  logic [VecW-1:0]  wr_word, rd_word, sum_word, relu_word;
  logic             accept, first_pass;

  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StDrain);
    busy      = (state_q == StAccum) || (state_q == StDrain);
    done      = done_q;
    out_data  = relu_word;
  end

  assign accept     = in_valid && in_ready;
  assign first_pass = (pass_cnt_q == '0);
  assign wr_word    = acc_q[wr_ptr_q];
  assign rd_word    = acc_q[rd_ptr_q];

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(
      .psum_bw(psum_bw)
    ) u_lane (
      .acc_i  (wr_word[i*psum_bw +: psum_bw]),
      .add_i  (in_data[i*psum_bw +: psum_bw]),
      .load_i (first_pass),
      .sum_o  (sum_word[i*psum_bw +: psum_bw]),
      .rd_i   (rd_word[i*psum_bw +: psum_bw]),
      .relu_o (relu_word[i*psum_bw +: psum_bw])
    );
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pass_cnt_d = pass_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAccum;
          wr_ptr_d   = '0;
          pass_cnt_d = '0;
        end
      end
      StAccum: begin
        if (accept) begin
          if (wr_ptr_q == LastAddr) begin
            wr_ptr_d   = '0;
            pass_cnt_d = pass_cnt_q + 1'b1;
            if (pass_cnt_q == LastPass) begin
              state_d  = StDrain;
              rd_ptr_d = '0;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (rd_ptr_q == LastAddr) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pass_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pass_cnt_q <= pass_cnt_d;
      done_q     <= done_d;
    end
  end

  // Buffer is never reset: pass 0 overwrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q[wr_ptr_q] <= sum_word;
    end
  end

endmodule

// File: tb/tb_sfp_accum.sv
// Directed bench for sfp_accum. Three instances share clock, reset, in_valid, in_data
// and out_ready; each has its own start so only the selected one runs a tile.
//   a: depth=4,  pass_num=1   c: depth=2, pass_num=2   b: depth=16, pass_num=9
module tb_sfp_accum;

  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    start_v;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  wire  [2:0]    in_ready_v, out_valid_v, done_v, busy_v;
  wire  [DW-1:0] od_a, od_b, od_c;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_vec [16];

  sfp_accum #(.psum_bw(16), .col(8), .depth(4), .pass_num(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .in_data(in_data), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(od_a), .done(done_v[0]), .busy(busy_v[0])
  );

  sfp_accum #(.psum_bw(16), .col(8), .depth(16), .pass_num(9)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .in_data(in_data), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(od_b), .done(done_v[1]), .busy(busy_v[1])
  );

  sfp_accum #(.psum_bw(16), .col(8), .depth(2), .pass_num(2)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .in_valid(in_valid),
    .in_ready(in_ready_v[2]), .in_data(in_data), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(od_c), .done(done_v[2]), .busy(busy_v[2])
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] od(input int sel);
    return (sel == 0) ? od_a : (sel == 1) ? od_b : od_c;
  endfunction

  function automatic logic [DW-1:0] splat(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(v);
    return r;
  endfunction

  // Position-dependent beat: lane i = base+i+1+p, lane 3 = -2-p (always negative).
  function automatic logic [DW-1:0] beat(input int base, input int p);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i == 3) ? 16'(-2 - p) : 16'(base + i + 1 + p);
    return r;
  endfunction

  function automatic logic [DW-1:0] beat_exp(input int base, input int p, input int npass);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i == 3) ? 16'(0) : 16'(npass * (base + i + 1 + p));
    return r;
  endfunction

  task automatic start_tile(input int sel);
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    check("start_busy", busy_v[sel], 1);
    check("start_in_ready", in_ready_v[sel], 1);
    check("done_low_after_pulse", done_v[sel], 0);
  endtask

  task automatic push_beat(input int sel, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    check("in_ready", in_ready_v[sel], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_tile(input int sel, input int dep, input int npass, input int base,
                          input bit gaps);
    for (int ps = 0; ps < npass; ps++) begin
      for (int p = 0; p < dep; p++) begin
        if (gaps) begin
          int g = $urandom_range(0, 2);
          // start is held high through gaps; it must be ignored outside Idle.
          repeat (g) begin
            start_v[sel] = 1'b1;
            in_data = splat(999);
            @(posedge clk); #1;
          end
          start_v[sel] = 1'b0;
        end
        push_beat(sel, beat(base, p));
      end
    end
  endtask

  // Drains n results against exp_vec; stall_at holds out_ready low 2 cycles at that position.
  task automatic drain(input int sel, input int n, input int stall_at);
    check("drain_in_ready", in_ready_v[sel], 0);
    for (int p = 0; p < n; p++) begin
      if (p == stall_at) begin
        out_ready = 1'b0;
        repeat (2) begin
          check("stall_valid", out_valid_v[sel], 1);
          check("stall_data", od(sel), exp_vec[p]);
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      check("out_valid", out_valid_v[sel], 1);
      check("out_data", od(sel), exp_vec[p]);
      check("no_done_mid_drain", done_v[sel], 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("done_pulse", done_v[sel], 1);
    check("idle_busy", busy_v[sel], 0);
    check("idle_out_valid", out_valid_v[sel], 0);
  endtask

  initial begin
    reset     = 1'b1;
    start_v   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {125'd0, in_ready_v}, 0);
    check("rst_out_valid", {125'd0, out_valid_v}, 0);
    check("rst_done", {125'd0, done_v}, 0);
    check("rst_busy", {125'd0, busy_v}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single pass, depth 4: 5, -3, 0, 7 -> 5, 0, 0, 7.
    start_tile(0);
    push_beat(0, splat(5));
    push_beat(0, splat(-3));
    push_beat(0, splat(0));
    push_beat(0, splat(7));
    exp_vec[0] = splat(5);
    exp_vec[1] = splat(0);
    exp_vec[2] = splat(0);
    exp_vec[3] = splat(7);
    drain(0, 4, -1);
    @(posedge clk); #1;
    check("a_done_one_cycle", done_v[0], 0);

    // Backpressure: out_ready 1,0,0,1 around position 1.
    start_tile(0);
    run_tile(0, 4, 1, 0, 1'b0);
    for (int p = 0; p < 4; p++) exp_vec[p] = beat_exp(0, p, 1);
    drain(0, 4, 1);
    @(posedge clk); #1;

    // Overflow: 30000 + 30000 wraps to -5536 (ReLU 0) or saturates to 32767.
    start_tile(2);
    push_beat(2, splat(30000));
    push_beat(2, splat(100));
    push_beat(2, splat(30000));
    push_beat(2, splat(50));
`ifdef SFP_SATURATE_EN
    exp_vec[0] = splat(32767);
`else
    exp_vec[0] = splat(0);
`endif
    exp_vec[1] = splat(150);
    drain(2, 2, -1);
    @(posedge clk); #1;

    // Nine-pass accumulation, gap-free.
    start_tile(1);
    run_tile(1, 16, 9, 0, 1'b0);
    for (int p = 0; p < 16; p++) exp_vec[p] = beat_exp(0, p, 9);
    drain(1, 16, -1);
    // New start in the done cycle; random gaps and start pokes must not change results.
    start_tile(1);
    run_tile(1, 16, 9, 0, 1'b1);
    drain(1, 16, -1);
    @(posedge clk); #1;

    // Reset partway into pass 3, then a fresh tile with different data.
    start_tile(1);
    for (int k = 0; k < 3 * 16 + 5; k++) push_beat(1, beat(0, k % 16));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", in_ready_v[1], 0);
    check("midrst_busy", busy_v[1], 0);
    check("midrst_out_valid", out_valid_v[1], 0);
    start_tile(1);
    run_tile(1, 16, 9, 10, 1'b0);
    for (int p = 0; p < 16; p++) exp_vec[p] = beat_exp(10, p, 9);
    drain(1, 16, -1);
    @(posedge clk); #1;
    check("b_done_one_cycle", done_v[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
